// File: rtl/circular_shifter_left_byte_n_if.sv
// Handshake/data bundle for the byte-granular left rotator.
// Carries one word plus rotate distance in and one rotated word out.
// No ready signal: the consumer must accept every out_valid beat.
interface circular_shifter_left_byte_n_if #(
    parameter int N = 128
);
    localparam int SW = $clog2(N / 8);

    logic          in_valid;
    logic [N-1:0]  shifting;
    logic [SW-1:0] shift_amount;
    logic          out_valid;
    logic [N-1:0]  shifted;

    // Producer side: drives the word and distance, observes the result.
    modport master (
        output in_valid,
        output shifting,
        output shift_amount,
        input  out_valid,
        input  shifted
    );

    // Rotator side.
    modport slave (
        input  in_valid,
        input  shifting,
        input  shift_amount,
        output out_valid,
        output shifted
    );
endinterface

// File: rtl/circular_shifter_left_byte_n.sv
// Rotates an N-bit word left by whole bytes (log2 barrel, per-stage mod-B amounts).
// Latency 1 cycle; 2 cycles when SHIFTER_IN_REG_EN is defined (adds input register).
// No backpressure: accepts one word per cycle, output beats must be taken as produced.
module circular_shifter_left_byte_n #(
    parameter int N = 128
) (
    input  logic                          clk,
    input  logic                          rst_n,
    circular_shifter_left_byte_n_if.slave bus
);
    localparam int B  = N / 8;
    localparam int SW = $clog2(B);

    // Reject word widths that are not whole bytes or too narrow to rotate.
    generate
        if ((N % 8) != 0 || N < 16) begin : g_bad_width
            $error("circular_shifter_left_byte_n: N must be a multiple of 8 and >= 16");
        end
    endgenerate

    logic          in_v;
    logic [N-1:0]  in_d;
    logic [SW-1:0] in_sa;

`ifdef SHIFTER_IN_REG_EN
    // Optional input stage: breaks the path from the producer into the barrel.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            in_v  <= 1'b0;
            in_d  <= '0;
            in_sa <= '0;
        end else begin
            in_v  <= bus.in_valid;
            in_d  <= bus.shifting;
            in_sa <= bus.shift_amount;
        end
    end
`else
    assign in_v  = bus.in_valid;
    assign in_d  = bus.shifting;
    assign in_sa = bus.shift_amount;
`endif

    // Barrel stages: stage i rotates by 2^i bytes when in_sa[i] is set.
    // Each stage distance is reduced mod B at elaboration, so the summed
    // rotation is already in_sa mod B; this is the modulo correction and it
    // costs nothing when B is a power of two (no reduction happens).
    logic [N-1:0] stage [SW+1];

    assign stage[0] = in_d;

    generate
        for (genvar i = 0; i < SW; i++) begin : g_stage
            localparam int K = (1 << i) % B;
            if (K == 0) begin : g_pass
                assign stage[i+1] = stage[i];
            end else begin : g_rot
                assign stage[i+1] = in_sa[i]
                    ? {stage[i][N-1-8*K:0], stage[i][N-1:N-8*K]}
                    : stage[i];
            end
        end
    endgenerate

    logic         out_v_q;
    logic [N-1:0] shifted_q;

    // Output register: data only loads on a valid beat so idle cycles hold it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_v_q   <= 1'b0;
            shifted_q <= '0;
        end else begin
            out_v_q <= in_v;
            if (in_v) begin
                shifted_q <= stage[SW];
            end
        end
    end

    assign bus.out_valid = out_v_q;
    assign bus.shifted   = shifted_q;
endmodule

// File: tb/tb_circular_shifter_left_byte_n.sv
// Self-checking bench for circular_shifter_left_byte_n (N=128).
// Expected words come from a byte-array rotation model; a scoreboard queue
// tags each accepted beat with its cycle so latency is checked too.
module tb_circular_shifter_left_byte_n;
    localparam int N = 128;
    localparam int B = N / 8;
`ifdef SHIFTER_IN_REG_EN
    localparam int L = 2;
`else
    localparam int L = 1;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    circular_shifter_left_byte_n_if #(.N(N)) bus();

    circular_shifter_left_byte_n #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [N-1:0] d;
        int           cyc;
    } exp_t;

    exp_t         q[$];
    int           tests    = 0;
    int           fails    = 0;
    int           cyc      = 0;
    int           received = 0;
    bit           started  = 1'b0;
    logic [N-1:0] last_exp = '0;

    // Directed beats carry a hand-written expected word.
    bit           drv_const = 1'b0;
    logic [N-1:0] drv_exp   = '0;

    // Reference: output byte (k+s) mod B takes input byte k.
    function automatic logic [N-1:0] rotl_ref(input logic [N-1:0] w, input int sa);
        logic [7:0]   b [B];
        logic [N-1:0] r;
        int           s;
        s = sa % B;
        for (int k = 0; k < B; k++) b[(k + s) % B] = w[8*k +: 8];
        for (int k = 0; k < B; k++) r[8*k +: 8] = b[k];
        return r;
    endfunction

    function automatic logic [N-1:0] rand_word();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Acceptance side: record what the DUT takes at each rising edge.
    always @(posedge clk) begin
        if (!rst_n) begin
            q.delete();
            last_exp = '0;
            started  = 1'b1;
        end else if (bus.in_valid) begin
            q.push_back('{drv_const ? drv_exp
                                    : rotl_ref(bus.shifting, int'(bus.shift_amount)),
                          cyc});
        end
        cyc++;
    end

    // Monitor: compare every presented output, and hold behaviour when idle.
    always @(negedge clk) begin
        if (started) begin
            if (bus.out_valid) begin
                tests++;
                if (q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_output: got out_valid=1 shifted=%h, none expected",
                             bus.shifted);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    received++;
                    if (bus.shifted !== e.d) begin
                        fails++;
                        $display("FAIL data: got %h expected %h", bus.shifted, e.d);
                    end
                    tests++;
                    if (cyc - e.cyc != L) begin
                        fails++;
                        $display("FAIL latency: got %0d expected %0d", cyc - e.cyc, L);
                    end
                    last_exp = e.d;
                end
            end else begin
                tests++;
                if (bus.shifted !== last_exp) begin
                    fails++;
                    $display("FAIL hold_or_reset: got %h expected %h", bus.shifted, last_exp);
                end
            end
        end
    end

    task automatic drive(input bit v, input logic [N-1:0] d, input int sa,
                         input bit use_const, input logic [N-1:0] exp_d);
        @(negedge clk);
        bus.in_valid     = v;
        bus.shifting     = d;
        bus.shift_amount = sa[3:0];
        drv_const        = use_const;
        drv_exp          = exp_d;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, rand_word(), 0, 1'b0, '0);
    endtask

    localparam logic [N-1:0] REF_W = 128'hFFEEDDCCBBAA99887766554433221100;

    initial begin
        bus.in_valid     = 1'b1;
        bus.shifting     = rand_word();
        bus.shift_amount = 4'd5;

        // Reset with valid traffic present: must be ignored.
        drive(1'b1, rand_word(), 7, 1'b0, '0);
        drive(1'b1, rand_word(), 2, 1'b0, '0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.in_valid = 1'b0;

        // Reference and edge distances.
        drive(1'b1, REF_W, 3,  1'b1, 128'hCCBBAA99887766554433221100FFEEDD);
        drive(1'b1, REF_W, 0,  1'b1, 128'hFFEEDDCCBBAA99887766554433221100);
        drive(1'b1, REF_W, 1,  1'b1, 128'hEEDDCCBBAA99887766554433221100FF);
        drive(1'b1, REF_W, 15, 1'b1, 128'h00FFEEDDCCBBAA998877665544332211);
        idle(3);

        // Streaming every distance back to back.
        for (int sa = 0; sa < B; sa++) drive(1'b1, rand_word(), sa, 1'b0, '0);

        // Single beat then idle: result must hold.
        idle(2);
        drive(1'b1, rand_word(), 9, 1'b0, '0);
        idle(3);

        // Reset in the middle of back-to-back traffic.
        for (int i = 0; i < 6; i++) drive(1'b1, rand_word(), int'($urandom_range(0, 15)), 1'b0, '0);
        @(negedge clk);
        rst_n = 1'b0;
        bus.shifting = rand_word();
        drive(1'b1, rand_word(), 4, 1'b0, '0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.in_valid = 1'b0;
        idle(4);

        // Random traffic with gaps.
        for (int i = 0; i < 300; i++)
            drive($urandom_range(0, 3) != 0, rand_word(), int'($urandom_range(0, 15)), 1'b0, '0);
        idle(6);

        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d outstanding beats, expected 0", q.size());
        end
        tests++;
        if (received < 100) begin
            fails++;
            $display("FAIL output_count: got %0d outputs, expected at least 100", received);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
